// File: rtl/timer_scheduler_pkg.sv
// timer_sched_pkg: state encoding and default sizing shared by timer_scheduler and its prescaler.
package timer_sched_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;
  localparam int DEF_DIV_CYCLES = 1000;
  localparam int DEF_CNT_W      = 10;
endpackage

// File: rtl/timer_scheduler_tick_prescaler.sv
// tick_prescaler: counts 0..DIV_CYCLES-1 while enabled and emits a one-cycle tick on the wrap cycle.
module tick_prescaler
  import timer_sched_pkg::*;
#(
  parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
  input  logic clock_i,
  input  logic rst_n_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic tick_o
);
  localparam int W = $clog2(DIV_CYCLES);
  localparam logic [W-1:0] LAST = W'(DIV_CYCLES - 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign tick_o = enable_i && cnt_q == LAST;
  assign cnt_d  = clear_i ? '0 : !enable_i ? cnt_q : tick_o ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clock_i or negedge rst_n_i)
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
endmodule

// File: rtl/timer_scheduler.sv
// timer_scheduler: one prescaler+countdown timer time-shared round-robin between NUM_REQ requesters.
// Optional freeze input pause_i is built only when TIMER_SCHED_PAUSE_EN is defined.
module timer_scheduler
  import timer_sched_pkg::*;
#(
  parameter int DIV_CYCLES = DEF_DIV_CYCLES,
  parameter int NUM_REQ    = 2,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                     clock_i,
  input  logic                     rst_n_i,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*CNT_W-1:0] dur_i,
`ifdef TIMER_SCHED_PAUSE_EN
  input  logic                     pause_i,
`endif
  output logic [NUM_REQ-1:0]       grant_o,
  output logic [NUM_REQ-1:0]       done_o,
  output logic                     busy_o,
  output logic                     tick_o
);
  localparam int IW = $clog2(NUM_REQ);
  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]      owner_q, owner_d, ptr_q, ptr_d, ptr_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               frozen, pre_clear, pre_en, pre_tick, found;
  int                 idx;
`ifdef TIMER_SCHED_PAUSE_EN
  assign frozen = pause_i;
`else
  assign frozen = 1'b0;
`endif
  assign ptr_nxt = IW'((int'(owner_q) + 1) % NUM_REQ);
  assign grant_o = grant_q;
  assign done_o  = state_q == ST_DONE ? grant_q : '0;
  assign busy_o  = state_q != ST_IDLE;
  assign tick_o  = pre_tick;
  tick_prescaler #(.DIV_CYCLES(DIV_CYCLES)) u_pre (
    .clock_i (clock_i),
    .rst_n_i (rst_n_i),
    .clear_i (pre_clear),
    .enable_i(pre_en),
    .tick_o  (pre_tick)
  );
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    pre_clear = 1'b1;
    pre_en    = 1'b0;
    found     = 1'b0;
    idx       = 0;
    case (state_q)
      ST_IDLE: begin
        for (int j = 0; j < NUM_REQ; j++) begin
          idx = (int'(ptr_q) + j) % NUM_REQ;
          if (!found && req_i[idx]) begin
            found   = 1'b1;
            owner_d = IW'(idx);
            grant_d = NUM_REQ'(1) << idx;
            cnt_d   = dur_i[idx*CNT_W +: CNT_W];
            state_d = dur_i[idx*CNT_W +: CNT_W] == '0 ? ST_DONE : ST_RUN;
          end
        end
      end
      ST_RUN: begin
        pre_clear = 1'b0;
        pre_en    = !frozen;
        // abort outranks a final tick landing in the same cycle
        if (!req_i[owner_q]) begin
          state_d = ST_IDLE;
          grant_d = '0;
          ptr_d   = ptr_nxt;
        end else if (pre_tick) begin
          cnt_d   = cnt_q - 1'b1;
          state_d = cnt_q == CNT_W'(1) ? ST_DONE : ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        grant_d = '0;
        ptr_d   = ptr_nxt;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clock_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
endmodule

// File: tb/tb_timer_scheduler.sv
// tb_timer_scheduler: directed cycle-accurate checks of timer_scheduler with DIV_CYCLES=4, NUM_REQ=2, CNT_W=4.
module tb_timer_scheduler;
  localparam int DIV = 4;
  localparam int NR  = 2;
  localparam int CW  = 4;
  logic clock_i = 1'b0;
  logic rst_n_i = 1'b0;
  logic [NR-1:0] req_i = '0;
  logic [NR*CW-1:0] dur_i = '0;
`ifdef TIMER_SCHED_PAUSE_EN
  logic pause_i = 1'b0;
`endif
  logic [NR-1:0] grant_o, done_o;
  logic busy_o, tick_o;
  int n_chk = 0;
  int n_err = 0;
  always #5 clock_i = ~clock_i;
  timer_scheduler #(.DIV_CYCLES(DIV), .NUM_REQ(NR), .CNT_W(CW)) dut (
    .clock_i(clock_i),
    .rst_n_i(rst_n_i),
    .req_i  (req_i),
    .dur_i  (dur_i),
`ifdef TIMER_SCHED_PAUSE_EN
    .pause_i(pause_i),
`endif
    .grant_o(grant_o),
    .done_o (done_o),
    .busy_o (busy_o),
    .tick_o (tick_o)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clock_i);
    #1;
  endtask
  task automatic expect_cycle(input string tag, input int t, input logic [1:0] g, input logic [1:0] d, input logic k);
    check($sformatf("%s grant t%0d", tag, t), 32'(grant_o), 32'(g));
    check($sformatf("%s done t%0d", tag, t), 32'(done_o), 32'(d));
    check($sformatf("%s tick t%0d", tag, t), 32'(tick_o), 32'(k));
    check($sformatf("%s busy t%0d", tag, t), 32'(busy_o), 32'(g != 2'b00));
  endtask
  initial begin
    req_i = 2'b11;
    dur_i = 8'h21;
    repeat (3) step();
    check("reset grant", 32'(grant_o), 32'h0);
    check("reset done", 32'(done_o), 32'h0);
    check("reset busy", 32'(busy_o), 32'h0);
    check("reset tick", 32'(tick_o), 32'h0);
    rst_n_i = 1'b1;
    step();
    for (int t = 0; t <= 16; t++) begin
      if (t > 0) step();
      expect_cycle("contend", t,
        t <= 4 ? 2'b01 : (t == 5 || t == 15) ? 2'b00 : t <= 14 ? 2'b10 : 2'b01,
        t == 4 ? 2'b01 : t == 14 ? 2'b10 : 2'b00,
        t == 3 || t == 9 || t == 13);
    end
    req_i = 2'b00;
    repeat (3) step();
    req_i = 2'b01;
    dur_i = 8'h03;
    step();
    for (int t = 0; t <= 13; t++) begin
      if (t > 0) step();
      expect_cycle("single", t, t <= 12 ? 2'b01 : 2'b00, t == 12 ? 2'b01 : 2'b00,
        t == 3 || t == 7 || t == 11);
      if (t == 1) dur_i = 8'h01;
      if (t == 12) req_i = 2'b00;
    end
    req_i = 2'b10;
    dur_i = 8'h05;
    step();
    expect_cycle("zero", 0, 2'b10, 2'b10, 1'b0);
    req_i = 2'b00;
    step();
    expect_cycle("zero", 1, 2'b00, 2'b00, 1'b0);
    req_i = 2'b01;
    step();
    for (int t = 0; t <= 10; t++) begin
      if (t > 0) step();
      expect_cycle("abort", t, t <= 6 ? 2'b01 : 2'b00, 2'b00, t == 3);
      if (t == 6) req_i = 2'b00;
    end
    req_i = 2'b01;
    step();
    for (int t = 0; t <= 5; t++) begin
      if (t > 0) step();
      expect_cycle("arst", t, 2'b01, 2'b00, t == 3);
    end
    #2 rst_n_i = 1'b0;
    #1;
    check("arst async grant", 32'(grant_o), 32'h0);
    check("arst async busy", 32'(busy_o), 32'h0);
    check("arst async tick", 32'(tick_o), 32'h0);
    check("arst async done", 32'(done_o), 32'h0);
    req_i = 2'b00;
    repeat (2) step();
    check("arst held done", 32'(done_o), 32'h0);
    rst_n_i = 1'b1;
    step();
`ifdef TIMER_SCHED_PAUSE_EN
    req_i = 2'b01;
    dur_i = 8'h02;
    step();
    for (int t = 0; t <= 12; t++) begin
      if (t > 0) step();
      expect_cycle("pause", t, t <= 11 ? 2'b01 : 2'b00, t == 11 ? 2'b01 : 2'b00,
        t == 6 || t == 10);
      if (t == 2) pause_i = 1'b1;
      if (t == 5) pause_i = 1'b0;
      if (t == 11) req_i = 2'b00;
    end
`endif
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/timer_scheduler.md
# timer_scheduler

Shared timeout scheduler for the lab's sequencing FSMs: a single prescaler-plus-countdown timer is time-shared between `NUM_REQ` requesters under round-robin arbitration. A requester raises `req` with a duration in ticks, receives a one-hot `grant`, and gets a one-cycle `done` pulse when its timeout has elapsed. The block replaces per-FSM clock dividers: it produces single-cycle tick enables on the system clock instead of derived clocks.

## Interface
- `DIV_CYCLES`, 1000: system-clock cycles per tick, at least 2.
- `NUM_REQ`, 2: number of requesters, 2..4.
- `CNT_W`, 10: width of each duration field, in ticks.
- `clock`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_REQ  level request per requester.
- `dur`  in  NUM_REQ*CNT_W  flattened durations; requester i uses bits [i*CNT_W +: CNT_W]; sampled only at grant.
- `pause`  in  1  freezes the timer; present only with `TIMER_SCHED_PAUSE_EN`.
- `grant`  out  NUM_REQ  one-hot owner of the timer, or zero.
- `done`  out  NUM_REQ  one-cycle completion pulse to the owner.
- `busy`  out  1  high when state is not IDLE.
- `tick`  out  1  one-cycle tick enable, RUN state only.

## Operation
- Reset values: state IDLE; `grant`, `done`, `busy` and `tick` all 0; round-robin pointer 0; prescaler 0; count 0.
- **IDLE**
  - Search `req` starting at the pointer and wrapping modulo NUM_REQ. The first set bit k wins.
  - Register `grant` = onehot(k). Load count = dur[k]. Clear the prescaler.
  - If dur[k]=0, go to DONE. Otherwise go to RUN.
- **RUN**
  - Prescaler counts 0..DIV_CYCLES-1 and then wraps.
  - On the wrap cycle: `tick`=1 and count decrements.
  - When the wrap cycle has count==1, go to DONE.
- **DONE**
  - `done[k]`=1 and `grant` held for this single cycle.
  - Pointer becomes (k+1) mod NUM_REQ. Go to IDLE.
- **Abort**: if req[k] falls while in RUN, go to IDLE on the next edge.
  - `grant` clears, no `done` pulse.
  - Pointer advances as in DONE.
- Requesters must drop `req` after `done`. A `req` still high in IDLE counts as a new request.
- Changes to `dur` after the grant are ignored.
- Losing requesters keep `req` high and wait. There is no starvation: the pointer rotates after every grant.
- Count arithmetic is unsigned CNT_W. It never decrements below 1 in RUN. The prescaler is $clog2(DIV_CYCLES) bits wide.

## Timing
- Let the grant cycle G be the first cycle with `grant` high (state RUN or DONE). `req` sampled high at edge e gives `grant` visible after e, so latency from request to grant is 1 cycle.
- For duration d≥1:
  - Ticks occur at G+n·DIV_CYCLES−1 for n=1..d.
  - `done` is asserted at G+d·DIV_CYCLES.
  - `grant` is high from G through G+d·DIV_CYCLES inclusive.
- For d=0: `grant` and `done` are both high in cycle G only.
- Back-to-back grants: at least one IDLE cycle lies between DONE and the next grant.
- Asynchronous reset mid-RUN immediately clears all outputs and the pointer. No `done` is issued.
- Abort in the same cycle as the final tick: the abort wins and no `done` is issued.

## Configuration
- `TIMER_SCHED_PAUSE_EN` defined:
  - The `pause` port exists.
  - While `pause`=1 in RUN, the prescaler and count hold and `tick` is 0. Timing resumes exactly where it stopped.
  - Abort detection remains active during pause.
  - `pause` has no effect in IDLE or DONE.
- Macro undefined: no `pause` port, and the timer is never frozen.

## Structure
- Package `timer_sched_pkg` holds:
  - state encoding constants `ST_IDLE`, `ST_RUN`, `ST_DONE`;
  - the default values of `DIV_CYCLES` and `CNT_W`.
- One sub-module, `tick_prescaler`:
  - ports: clock, rst_n, clear, enable, tick;
  - parameter DIV_CYCLES;
  - instantiated once.
- Arbitration, countdown and FSM live in the top.

## Test plan
All scenarios use DIV_CYCLES=4, NUM_REQ=2, CNT_W=4.
- Reset: hold `rst_n` low with req=2'b11 -> all outputs 0. On release, grant=2'b01 on the first edge (pointer 0).
- Single request: req0=1, dur0=3 -> ticks at G+3, G+7, G+11; done=2'b01 at G+12; grant then low.
- Contention: req=2'b11, dur0=1, dur1=2 -> requester 0 served first, done at G+4. After one IDLE cycle grant=2'b10, with done 8 cycles after its grant. Then the pointer returns to 0.
- Zero duration and abort:
  - dur1=0 -> grant=done=2'b10 for exactly one cycle.
  - Separately, req0=1, dur0=5, req0 dropped at G+6 -> grant clears, no done.
- Asynchronous reset mid-RUN: pull `rst_n` low at G+5 -> grant, busy and tick drop without waiting for a clock edge. No done.
- `TIMER_SCHED_PAUSE_EN`: dur0=2 with pause high for 3 cycles starting at G+2 -> done moves from G+8 to G+11.
